// File: rtl/systolic_pkg.sv
// Shared types for the systolic array output path: partial-sum word and packed row vector.
package systolic_pkg;

  localparam int DATAWIDTH_output = 32;
  localparam int COLS_DEFAULT     = 4;

  typedef logic [DATAWIDTH_output-1:0] psum_t;
  // Column j lives at bits [j*DATAWIDTH_output +: DATAWIDTH_output].
  typedef psum_t [COLS_DEFAULT-1:0]    row_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead head, occupancy count and synchronous clear.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the head is forced to zero while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/systolic_out_deskew.sv
// Bottom-edge collector: deskews staggered column outputs into rows, buffers them in a FIFO,
// and throttles the feeder. Optional alignment checker enabled by `define OUT_DESKEW_CHECK_EN.
module systolic_out_deskew #(
  parameter int COLS             = 4,
  parameter int DATAWIDTH_output = systolic_pkg::DATAWIDTH_output,
  parameter int DEPTH            = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic [COLS-1:0]                  col_valid,
  input  logic [COLS*DATAWIDTH_output-1:0] col_data,
  output logic                             row_valid,
  input  logic                             row_ready,
  output logic [COLS*DATAWIDTH_output-1:0] row_data,
  output logic                             hold,
  output logic                             overflow,
  output logic                             skew_err
);

  localparam int W  = DATAWIDTH_output;
  localparam int AW = $clog2(DEPTH);

  logic [COLS-1:0]   aligned_valid;
  logic [COLS*W-1:0] aligned_data;
  logic              push_req, pop, fifo_full, fifo_empty;
  logic [AW:0]       fifo_count;
  logic              overflow_q, overflow_d;

  // Column j waits COLS-1-j cycles so it lines up with the last column.
  for (genvar j = 0; j < COLS; j++) begin : g_col
    localparam int N = COLS - 1 - j;
    if (N == 0) begin : g_pass
      assign aligned_valid[j]        = col_valid[j];
      assign aligned_data[j*W +: W]  = col_data[j*W +: W];
    end else begin : g_dly
      logic [N-1:0] v_q;
      logic [W-1:0] d_q [N];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= '0;
          for (int k = 0; k < N; k++) d_q[k] <= '0;
        end else begin
          // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its predecessor.
          v_q[0] <= clear ? 1'b0 : col_valid[j];
          d_q[0] <= col_data[j*W +: W];
          for (int k = 1; k < N; k++) begin
            v_q[k] <= clear ? 1'b0 : v_q[k-1];
            d_q[k] <= d_q[k-1];
          end
        end
      end

      assign aligned_valid[j]       = v_q[N-1];
      assign aligned_data[j*W +: W] = d_q[N-1];
    end
  end

  assign push_req  = &aligned_valid;
  assign pop       = row_valid && row_ready;
  assign row_valid = !fifo_empty;

  sync_fifo #(
    .WIDTH (COLS*W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push_req),
    .pop   (pop),
    .wdata (aligned_data),
    .rdata (row_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Rows already inside the skew stages still land after hold rises, so reserve COLS slots.
  assign hold = (fifo_count >= (AW+1)'(DEPTH - COLS));

  assign overflow_d = clear ? 1'b0 : (overflow_q | (push_req && fifo_full && !pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;

`ifdef OUT_DESKEW_CHECK_EN
  logic skew_err_q, skew_err_d;

  assign skew_err_d = clear ? 1'b0 : (skew_err_q | ((|aligned_valid) && !push_req));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) skew_err_q <= 1'b0;
    else        skew_err_q <= skew_err_d;
  end

  assign skew_err = skew_err_q;
`else
  assign skew_err = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_out_deskew.sv
// Randomised self-checking bench for systolic_out_deskew against a queue-based row model.
module tb_systolic_out_deskew;
  import systolic_pkg::*;

  localparam int COLS  = 4;
  localparam int W     = 32;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic [COLS-1:0]   col_valid = '0;
  logic [COLS*W-1:0] col_data = '0;
  logic              row_valid;
  logic              row_ready = 1'b0;
  logic [COLS*W-1:0] row_data;
  logic              hold, overflow, skew_err;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef OUT_DESKEW_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  systolic_out_deskew #(
    .COLS             (COLS),
    .DATAWIDTH_output (W),
    .DEPTH            (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .col_valid (col_valid),
    .col_data  (col_data),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .hold      (hold),
    .overflow  (overflow),
    .skew_err  (skew_err)
  );

  always #5 clk = ~clk;

  // Reference model: history of past column inputs, a queue of buffered rows, sticky flags.
  logic  hv [COLS][COLS];
  psum_t hd [COLS][COLS];
  row_t  mq [$];
  bit    m_ovf, m_skew;
  psum_t rows [64][COLS];

  function automatic row_t pack(int r);
    row_t v;
    for (int j = 0; j < COLS; j++) v[j] = rows[r][j];
    return v;
  endfunction

  function automatic row_t exp_head();
    return (mq.size() > 0) ? mq[0] : '0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_skew = 1'b0;
    for (int a = 0; a < COLS; a++)
      for (int j = 0; j < COLS; j++) begin
        hv[a][j] = 1'b0;
        hd[a][j] = '0;
      end
  endtask

  // Advance one clock edge and update the model with what the edge should have done.
  task automatic step();
    logic [COLS-1:0] al_v;
    row_t            al_d;
    bit              pop, full;
    for (int j = 0; j < COLS; j++) begin
      int a = COLS - 1 - j;
      if (a == 0) begin
        al_v[j] = col_valid[j];
        al_d[j] = col_data[j*W +: W];
      end else begin
        al_v[j] = hv[a][j];
        al_d[j] = hd[a][j];
      end
    end
    pop  = (mq.size() > 0) && row_ready;
    full = (mq.size() == DEPTH);
    @(posedge clk);
    if (clear) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_skew = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (&al_v) begin
        if (!full || pop) mq.push_back(al_d);
        else m_ovf = 1'b1;
      end
      if (CHECK_EN && (|al_v) && !(&al_v)) m_skew = 1'b1;
    end
    for (int a = COLS - 1; a >= 2; a--)
      for (int j = 0; j < COLS; j++) begin
        hv[a][j] = hv[a-1][j];
        hd[a][j] = hd[a-1][j];
      end
    for (int j = 0; j < COLS; j++) begin
      hv[1][j] = clear ? 1'b0 : col_valid[j];
      hd[1][j] = col_data[j*W +: W];
    end
    if (clear)
      for (int a = 1; a < COLS; a++)
        for (int j = 0; j < COLS; j++) hv[a][j] = 1'b0;
    #1;
  endtask

  // Row base+r enters column j at cycle c = r + j; idle columns carry random garbage.
  task automatic set_rows(int c, int n, int base);
    for (int j = 0; j < COLS; j++) begin
      int r = c - j;
      col_valid[j] = (r >= 0 && r < n);
      col_data[j*W +: W] = (r >= 0 && r < n) ? rows[base + r][j] : psum_t'($urandom);
    end
  endtask

  task automatic idle();
    col_valid = '0;
    col_data  = '0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({row_valid, hold, overflow, skew_err} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000", {row_valid, hold, overflow, skew_err});
    else n_pass++;
    n_checks++;
    if (row_data !== '0) $display("FAIL reset_data got %h want 0", row_data);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_staggered();
    row_t want;
    for (int j = 0; j < COLS; j++) want[j] = psum_t'(32'h10 + j);
    row_ready = 1'b0;
    idle();
    repeat (10) step();
    for (int c = 0; c < COLS; c++) begin
      for (int j = 0; j < COLS; j++) begin
        col_valid[j] = (c == j);
        col_data[j*W +: W] = (c == j) ? want[j] : psum_t'($urandom);
      end
      step();
      if (c == COLS - 2) begin
        n_checks++;
        if (row_valid !== 1'b0) $display("FAIL stagger_early got %b want 0", row_valid);
        else n_pass++;
      end
    end
    idle();
    n_checks++;
    if (row_valid !== 1'b1) $display("FAIL stagger_valid got %b want 1", row_valid);
    else n_pass++;
    n_checks++;
    if (row_data !== want) $display("FAIL stagger_data got %h want %h", row_data, want);
    else n_pass++;
    row_ready = 1'b1;
    step();
    n_checks++;
    if (row_valid !== 1'b0) $display("FAIL stagger_pop got %b want 0", row_valid);
    else n_pass++;
  endtask

  task automatic test_streaming();
    int k = 0;
    int errs = 0;
    row_ready = 1'b1;
    for (int c = 0; c < 8 + COLS; c++) begin
      set_rows(c, 8, 0);
      step();
      if (hold !== 1'b0) errs++;
      if (row_valid) begin
        if (row_data !== pack(k)) errs++;
        k++;
      end
    end
    idle();
    n_checks++;
    if (k !== 8) $display("FAIL stream_count got %0d want 8", k);
    else n_pass++;
    n_checks++;
    if (errs !== 0) $display("FAIL stream_order_hold got %0d errors want 0", errs);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int errs = 0;
    row_ready = 1'b0;
    for (int c = 0; c < 4 + COLS - 1; c++) begin
      set_rows(c, 4, 8);
      step();
      if (hold !== (mq.size() >= DEPTH - COLS)) errs++;
    end
    idle();
    n_checks++;
    if (errs !== 0 || hold !== 1'b1) $display("FAIL bp_hold got hold=%b errs=%0d want 1/0", hold, errs);
    else n_pass++;
    for (int c = 0; c < 5 + COLS - 1; c++) begin
      set_rows(c, 5, 12);
      step();
    end
    idle();
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL bp_overflow got %b want 1", overflow);
    else n_pass++;
    n_checks++;
    if (row_data !== pack(8)) $display("FAIL bp_head got %h want %h", row_data, pack(8));
    else n_pass++;
  endtask

  task automatic test_clear_push();
    row_ready = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      set_rows(c, 1, 20);
      clear = (c == COLS - 1);
      step();
    end
    clear = 1'b0;
    idle();
    n_checks++;
    if ({row_valid, overflow, hold} !== 3'b000)
      $display("FAIL clear_push got v/ovf/hold=%b want 000", {row_valid, overflow, hold});
    else n_pass++;
  endtask

  task automatic test_full_pop();
    int pops = 0;
    row_ready = 1'b0;
    for (int c = 0; c < 8 + COLS - 1; c++) begin
      set_rows(c, 8, 24);
      step();
    end
    for (int c = 0; c < COLS; c++) begin
      set_rows(c, 1, 32);
      row_ready = (c == COLS - 1);
      step();
    end
    row_ready = 1'b0;
    idle();
    n_checks++;
    if ({overflow, hold, row_valid} !== 3'b011)
      $display("FAIL fullpop_flags got ovf/hold/v=%b want 011", {overflow, hold, row_valid});
    else n_pass++;
    n_checks++;
    if (row_data !== pack(25)) $display("FAIL fullpop_head got %h want %h", row_data, pack(25));
    else n_pass++;
    row_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (row_valid) pops++;
      if (pops == DEPTH && row_valid) begin
        n_checks++;
        if (row_data !== pack(32)) $display("FAIL fullpop_last got %h want %h", row_data, pack(32));
        else n_pass++;
      end
      step();
    end
    n_checks++;
    if (pops !== DEPTH) $display("FAIL fullpop_drain got %0d rows want %0d", pops, DEPTH);
    else n_pass++;
  endtask

  task automatic test_skew();
    row_ready = 1'b1;
    for (int c = 0; c < COLS + 3; c++) begin
      for (int j = 0; j < COLS; j++) begin
        col_valid[j] = (j == 2) ? (c == 3) : (c == j);
        col_data[j*W +: W] = psum_t'($urandom);
      end
      step();
      n_checks++;
      if (row_valid !== 1'b0) $display("FAIL skew_nowrite c=%0d got %b want 0", c, row_valid);
      else n_pass++;
    end
    idle();
    n_checks++;
    if (skew_err !== CHECK_EN) $display("FAIL skew_flag got %b want %b", skew_err, CHECK_EN);
    else n_pass++;
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++;
    if (skew_err !== 1'b0) $display("FAIL skew_clear got %b want 0", skew_err);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [COLS-1:0] st = '0;
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      st = {st[COLS-2:0], ($urandom_range(3) != 0)};
      col_valid = st;
      if ($urandom_range(31) == 0) col_valid[$urandom_range(COLS-1)] ^= 1'b1;
      for (int j = 0; j < COLS; j++) col_data[j*W +: W] = psum_t'($urandom);
      row_ready = ($urandom_range(3) != 0);
      clear = ($urandom_range(63) == 0);
      step();
      if (row_valid !== (mq.size() > 0)) errs++;
      if (row_data !== exp_head()) errs++;
      if (hold !== (mq.size() >= DEPTH - COLS)) errs++;
      if (overflow !== m_ovf) errs++;
      if (skew_err !== m_skew) errs++;
      if (errs != 0 && i < 400) begin
        n_checks++;
        $display("FAIL random cycle=%0d v=%b d=%h h=%b o=%b s=%b want v=%b d=%h h=%b o=%b s=%b",
                 i, row_valid, row_data, hold, overflow, skew_err, mq.size() > 0, exp_head(),
                 mq.size() >= DEPTH - COLS, m_ovf, m_skew);
        break;
      end
    end
    clear = 1'b0;
    if (errs == 0) begin
      n_checks++;
      n_pass++;
    end
  endtask

  task automatic test_async_reset();
    row_ready = 1'b0;
    for (int c = 0; c < 2 + COLS - 1; c++) begin
      set_rows(c, 2, 40);
      step();
    end
    idle();
    n_checks++;
    if (row_valid !== 1'b1) $display("FAIL arst_pre got %b want 1", row_valid);
    else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({row_valid, hold, overflow, skew_err} !== 4'b0000 || row_data !== '0)
      $display("FAIL arst_now got v/h/o/s=%b d=%h want 0000 0",
               {row_valid, hold, overflow, skew_err}, row_data);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++;
    if (row_valid !== 1'b0) $display("FAIL arst_lost got %b want 0", row_valid);
    else n_pass++;
  endtask

  initial begin
    for (int r = 0; r < 64; r++)
      for (int j = 0; j < COLS; j++) rows[r][j] = psum_t'($urandom);
    test_reset();
    test_staggered();
    test_streaming();
    test_backpressure();
    test_clear_push();
    test_full_pop();
    test_skew();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
